// File: rtl/display_pkg.sv
// display_pkg: 640x480@60 timing, 320x240 frame-buffer geometry,
// RGB565 colour-bar constants and the sync bundle shared by stages.
package display_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int FB_COLS  = 320;
  localparam int FB_ROWS  = 240;
  localparam int RGB565_W = 16;

  localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
  localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
  localparam logic [15:0] BAR_CYAN    = 16'h07FF;
  localparam logic [15:0] BAR_GREEN   = 16'h07E0;
  localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
  localparam logic [15:0] BAR_RED     = 16'hF800;
  localparam logic [15:0] BAR_BLUE    = 16'h001F;
  localparam logic [15:0] BAR_BLACK   = 16'h0000;

  // Index 0 is the left-most bar.
  localparam logic [7:0][15:0] BAR_COLORS = {
    BAR_BLACK, BAR_BLUE, BAR_RED, BAR_MAGENTA,
    BAR_GREEN, BAR_CYAN, BAR_YELLOW, BAR_WHITE
  };

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic sof;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{
    de: 1'b0, hs: 1'b1, vs: 1'b1, sof: 1'b0
  };

  // Eight equal bars across the active width.
  function automatic logic [15:0] bar_color(
    input int unsigned x,
    input int unsigned bar_w
  );
    logic [2:0] idx;
    idx = '0;
    for (int unsigned i = 1; i < 8; i++)
      if (x >= i * bar_w) idx = 3'(i);
    return BAR_COLORS[idx];
  endfunction

endpackage

// File: rtl/fb_display_reader_if.sv
// fb_display_reader_if: frame-buffer read port (o_raddr/i_rdata) and
// video output (o_pixel, o_hsync, o_vsync, o_de, o_sof); master = reader.
interface fb_display_reader_if #(
  parameter int AW = 17,
  parameter int DW = 16
);

  logic [AW-1:0] o_raddr;
  logic [DW-1:0] i_rdata;
  logic [DW-1:0] o_pixel;
  logic          o_hsync;
  logic          o_vsync;
  logic          o_de;
  logic          o_sof;

  modport master (
    output o_raddr,
    input  i_rdata,
    output o_pixel,
    output o_hsync,
    output o_vsync,
    output o_de,
    output o_sof
  );

  modport slave (
    input  o_raddr,
    output i_rdata,
    input  o_pixel,
    input  o_hsync,
    input  o_vsync,
    input  o_de,
    input  o_sof
  );

endinterface

// File: rtl/vga_timing.sv
// vga_timing: free-running h/v counters with raw de, active-low syncs,
// sof and line_end. Ports: i_clk, i_rstn (sync, low), counters, flags.
module vga_timing import display_pkg::*; #(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic          de,
  output logic          hs_n,
  output logic          vs_n,
  output logic          sof,
  output logic          line_end
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      hcount <= '0;
      vcount <= '0;
    end else if (hcount == H_LAST) begin
      hcount <= '0;
      vcount <= (vcount == V_LAST) ? '0 : vcount + 1'b1;
    end else begin
      hcount <= hcount + 1'b1;
    end
  end

  always_comb begin
    de       = (hcount < H_ACT) && (vcount < V_ACT);
    hs_n     = !((hcount >= HS_BEG) && (hcount < HS_END));
    vs_n     = !((vcount >= VS_BEG) && (vcount < VS_END));
    sof      = (hcount == '0) && (vcount == '0);
    line_end = (hcount == H_LAST);
  end

endmodule

// File: rtl/fb_display_reader.sv
// fb_display_reader: 2x-upscaled frame-buffer scan-out, 3-cycle pipeline.
// Ports: i_clk, i_rstn (sync, low), bus (master); FB_TEST_PATTERN_EN adds i_test_mode.
module fb_display_reader import display_pkg::*; #(
  parameter int DATA_WIDTH = RGB565_W,
  parameter int H_ACTIVE   = VGA_H_ACTIVE,
  parameter int H_FP       = VGA_H_FP,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BP       = VGA_H_BP,
  parameter int V_ACTIVE   = VGA_V_ACTIVE,
  parameter int V_FP       = VGA_V_FP,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BP       = VGA_V_BP,
  parameter int FB_WIDTH   = FB_COLS,
  parameter int FB_HEIGHT  = FB_ROWS
) (
  input logic i_clk,
  input logic i_rstn,
`ifdef FB_TEST_PATTERN_EN
  input logic i_test_mode,
`endif
  fb_display_reader_if.master bus
);

  localparam int AW = $clog2(FB_WIDTH * FB_HEIGHT);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [AW-1:0] ROW_STEP = AW'(FB_WIDTH);

  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  logic          raw_de;
  logic          raw_hs;
  logic          raw_vs;
  logic          raw_sof;
  logic          line_end;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .HW       (HW),
    .VW       (VW)
  ) u_timing (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .hcount   (hcount),
    .vcount   (vcount),
    .de       (raw_de),
    .hs_n     (raw_hs),
    .vs_n     (raw_vs),
    .sof      (raw_sof),
    .line_end (line_end)
  );

  logic [AW-1:0]         row_base;
  logic [AW-1:0]         raddr;
  logic [DATA_WIDTH-1:0] src;
  logic [DATA_WIDTH-1:0] pixel;
  sync_t                 s0;
  sync_t                 s1;
  sync_t                 s2;
  sync_t                 s3;

  assign s0 = '{de: raw_de, hs: raw_hs, vs: raw_vs, sof: raw_sof};

  // Cleared on the edge entering line 0 so the first pixel of a
  // frame already sees zero; advanced after each odd active line.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      row_base <= '0;
    end else if (line_end) begin
      if (vcount == V_LAST)
        row_base <= '0;
      else if (vcount[0] && (vcount < V_ACT))
        row_base <= row_base + ROW_STEP;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      raddr <= '0;
      s1    <= SYNC_IDLE;
      s2    <= SYNC_IDLE;
      s3    <= SYNC_IDLE;
      pixel <= '0;
    end else begin
      if (raw_de)
        raddr <= row_base + AW'(hcount >> 1);
      s1    <= s0;
      s2    <= s1;
      s3    <= s2;
      pixel <= s2.de ? src : '0;
    end
  end

`ifdef FB_TEST_PATTERN_EN
  logic [DATA_WIDTH-1:0] bar1;
  logic [DATA_WIDTH-1:0] bar2;
  logic                  tp1;
  logic                  tp2;

  // Bar colour rides the same two stages as the BRAM read.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      bar1 <= '0;
      bar2 <= '0;
      tp1  <= 1'b0;
      tp2  <= 1'b0;
    end else begin
      bar1 <= DATA_WIDTH'(bar_color(32'(hcount), H_ACTIVE / 8));
      tp1  <= i_test_mode;
      bar2 <= bar1;
      tp2  <= tp1;
    end
  end

  assign src = tp2 ? bar2 : bus.i_rdata;
`else
  assign src = bus.i_rdata;
`endif

  assign bus.o_raddr = raddr;
  assign bus.o_pixel = pixel;
  assign bus.o_hsync = s3.hs;
  assign bus.o_vsync = s3.vs;
  assign bus.o_de    = s3.de;
  assign bus.o_sof   = s3.sof;

endmodule

// File: tb/tb_fb_display_reader.sv
// tb_fb_display_reader: random-stimulus bench for fb_display_reader
// against a frame-position reference model, on a reduced raster.
module tb_fb_display_reader;

  localparam int HA  = 32;
  localparam int HFP = 4;
  localparam int HS  = 6;
  localparam int HBP = 6;
  localparam int VA  = 16;
  localparam int VFP = 2;
  localparam int VS  = 2;
  localparam int VBP = 3;
  localparam int FBW = 16;
  localparam int FBH = 8;
  localparam int HT  = HA + HFP + HS + HBP;
  localparam int VT  = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam int AW  = $clog2(FBW * FBH);
  localparam int VECW = 16 + 4 + AW;

  logic i_clk  = 1'b0;
  logic i_rstn = 1'b0;
  logic tm     = 1'b0;

  always #5 i_clk = ~i_clk;

  fb_display_reader_if #(.AW(AW), .DW(16)) bus ();

  fb_display_reader #(
    .DATA_WIDTH (16),
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
    .FB_WIDTH (FBW), .FB_HEIGHT (FBH)
  ) dut (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
`ifdef FB_TEST_PATTERN_EN
    .i_test_mode (tm),
`endif
    .bus         (bus)
  );

  // Frame-buffer model: one-cycle read, data equals address.
  always @(posedge i_clk) bus.i_rdata <= 16'(bus.o_raddr);

  logic [VECW-1:0] dut_vec;
  logic [VECW-1:0] e_vec;

  assign dut_vec = {bus.o_pixel, bus.o_hsync, bus.o_vsync,
                    bus.o_de, bus.o_sof, bus.o_raddr};

  int n_cmp = 0;
  int n_bad = 0;
  int k = 0;
  int m_raddr = 0;
  int out_h = -1;
  int out_v = -1;
  logic tm_d0 = 1'b0;
  logic tm_d1 = 1'b0;
  logic tm_d2 = 1'b0;

  logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  function automatic bit act(input int h, input int v);
    return (h < HA) && (v < VA);
  endfunction

  function automatic int addr_of(input int h, input int v);
    return (v / 2) * FBW + h / 2;
  endfunction

  // k = edges since the last reset edge = raster position of the
  // counters; outputs show the position three edges earlier.
  task automatic tick();
    int h;
    int v;
    logic [15:0] px;
    logic hs, vs, de, sof;
    @(posedge i_clk);
    tm_d2 = tm_d1;
    tm_d1 = tm_d0;
    tm_d0 = tm;
    if (!i_rstn) begin
      k = 0;
      m_raddr = 0;
    end else begin
      h = k % HT;
      v = (k / HT) % VT;
      if (act(h, v)) m_raddr = addr_of(h, v);
      k++;
    end
    px = '0; hs = 1'b1; vs = 1'b1; de = 1'b0; sof = 1'b0;
    out_h = -1; out_v = -1;
    if (k >= 3) begin
      h = (k - 3) % HT;
      v = ((k - 3) / HT) % VT;
      out_h = h; out_v = v;
      de  = act(h, v);
      hs  = !(h >= HA + HFP && h < HA + HFP + HS);
      vs  = !(v >= VA + VFP && v < VA + VFP + VS);
      sof = (h == 0) && (v == 0);
      if (de) px = tm_d2 ? bars[h / (HA / 8)] : 16'(addr_of(h, v));
    end
    e_vec = {px, hs, vs, de, sof, AW'(m_raddr)};
    #1;
  endtask

  task automatic test_reset();
    i_rstn = 1'b0;
    repeat (4) begin
      tick();
      n_cmp++;
      if (dut_vec !== e_vec) begin
        n_bad++;
        $display("FAIL reset_vec got %h want %h", dut_vec, e_vec);
      end
    end
    n_cmp++;
    if (bus.o_hsync !== 1'b1 || bus.o_vsync !== 1'b1 ||
        bus.o_de !== 1'b0 || bus.o_sof !== 1'b0 ||
        bus.o_pixel !== 16'h0 || bus.o_raddr !== '0) begin
      n_bad++;
      $display("FAIL reset_vals got %h want hs=vs=1 rest 0", dut_vec);
    end
  endtask

  task automatic test_frame();
    int first_sof = -1;
    int last_sof = -1;
    int gaps = 0;
    int de_frame = 0;
    int de_line = 0;
    int max_px = -1;
    i_rstn = 1'b1;
    for (int c = 1; c <= 2 * FRAME + 8; c++) begin
      tick();
      n_cmp++;
      if (dut_vec !== e_vec) begin
        n_bad++;
        $display("FAIL frame_vec k=%0d got %h want %h", k, dut_vec, e_vec);
      end
      if (bus.o_sof === 1'b1) begin
        if (first_sof < 0) begin
          first_sof = c;
        end else begin
          gaps++;
          n_cmp++;
          if (c - last_sof != FRAME) begin
            n_bad++;
            $display("FAIL sof_period got %0d want %0d", c - last_sof, FRAME);
          end
          n_cmp++;
          if (de_frame != HA * VA) begin
            n_bad++;
            $display("FAIL de_per_frame got %0d want %0d", de_frame, HA * VA);
          end
        end
        last_sof = c;
        de_frame = 0;
      end
      if (bus.o_de === 1'b1) begin
        de_frame++;
        de_line++;
        if (int'(bus.o_pixel) > max_px) max_px = int'(bus.o_pixel);
      end else if (de_line != 0) begin
        n_cmp++;
        if (de_line != HA) begin
          n_bad++;
          $display("FAIL de_per_line got %0d want %0d", de_line, HA);
        end
        de_line = 0;
      end
      n_cmp++;
      if (int'(bus.o_raddr) > FBW * FBH - 1) begin
        n_bad++;
        $display("FAIL raddr_bound got %0d want <= %0d", bus.o_raddr, FBW * FBH - 1);
      end
    end
    n_cmp++;
    if (first_sof != 3) begin
      n_bad++;
      $display("FAIL first_sof got %0d want 3", first_sof);
    end
    n_cmp++;
    if (gaps != 2) begin
      n_bad++;
      $display("FAIL sof_count got %0d want 2", gaps);
    end
    n_cmp++;
    if (max_px != FBW * FBH - 1) begin
      n_bad++;
      $display("FAIL last_pixel got %0d want %0d", max_px, FBW * FBH - 1);
    end
  endtask

  task automatic test_sync();
    int c_de = -1;
    int c_hs = -1;
    int c_vs = -1;
    int nh = 0;
    int nv = 0;
    logic p_de, p_hs, p_vs;
    p_de = bus.o_de; p_hs = bus.o_hsync; p_vs = bus.o_vsync;
    for (int c = 0; c < 2 * FRAME; c++) begin
      tick();
      n_cmp++;
      if (dut_vec !== e_vec) begin
        n_bad++;
        $display("FAIL sync_vec k=%0d got %h want %h", k, dut_vec, e_vec);
      end
      if (p_de && !bus.o_de) c_de = c;
      if (p_hs && !bus.o_hsync) begin
        c_hs = c;
        if (c_de >= 0 && c - c_de < HT) begin
          nh++;
          n_cmp++;
          if (c - c_de != HFP) begin
            n_bad++;
            $display("FAIL hs_start got %0d want %0d", c - c_de, HFP);
          end
        end
      end
      if (!p_hs && bus.o_hsync && c_hs >= 0) begin
        n_cmp++;
        if (c - c_hs != HS) begin
          n_bad++;
          $display("FAIL hs_width got %0d want %0d", c - c_hs, HS);
        end
      end
      if (p_vs && !bus.o_vsync) begin
        c_vs = c;
        if (c_de >= 0) begin
          nv++;
          n_cmp++;
          if (c - c_de != (HT - HA) + VFP * HT) begin
            n_bad++;
            $display("FAIL vs_start got %0d want %0d", c - c_de, (HT - HA) + VFP * HT);
          end
        end
      end
      if (!p_vs && bus.o_vsync && c_vs >= 0) begin
        nv++;
        n_cmp++;
        if (c - c_vs != VS * HT) begin
          n_bad++;
          $display("FAIL vs_width got %0d want %0d", c - c_vs, VS * HT);
        end
      end
      p_de = bus.o_de; p_hs = bus.o_hsync; p_vs = bus.o_vsync;
    end
    n_cmp++;
    if (nh < VA || nv < 2) begin
      n_bad++;
      $display("FAIL sync_seen got hs=%0d vs=%0d want >=%0d >=2", nh, nv, VA);
    end
  endtask

  task automatic test_mid_reset();
    int found;
    for (int r = 0; r < 4; r++) begin
      repeat ($urandom_range(20, FRAME)) begin
        tick();
        n_cmp++;
        if (dut_vec !== e_vec) begin
          n_bad++;
          $display("FAIL pre_rst_vec k=%0d got %h want %h", k, dut_vec, e_vec);
        end
      end
      i_rstn = 1'b0;
      for (int c = 0; c < int'($urandom_range(1, 6)); c++) begin
        tick();
        n_cmp++;
        if (dut_vec !== e_vec) begin
          n_bad++;
          $display("FAIL rst_vec got %h want %h", dut_vec, e_vec);
        end
        if (c == 0) begin
          n_cmp++;
          if (bus.o_de !== 1'b0 || bus.o_hsync !== 1'b1 ||
              bus.o_vsync !== 1'b1 || bus.o_pixel !== 16'h0) begin
            n_bad++;
            $display("FAIL rst_next got %h want idle", dut_vec);
          end
        end
      end
      i_rstn = 1'b1;
      found = -1;
      for (int c = 1; c <= 8; c++) begin
        tick();
        n_cmp++;
        if (dut_vec !== e_vec) begin
          n_bad++;
          $display("FAIL post_rst_vec got %h want %h", dut_vec, e_vec);
        end
        if (c == 1) begin
          n_cmp++;
          if (bus.o_raddr !== '0) begin
            n_bad++;
            $display("FAIL raddr_restart got %0d want 0", bus.o_raddr);
          end
        end
        if (bus.o_sof === 1'b1 && found < 0) found = c;
      end
      n_cmp++;
      if (found != 3) begin
        n_bad++;
        $display("FAIL sof_after_rst got %0d want 3", found);
      end
    end
  endtask

`ifdef FB_TEST_PATTERN_EN
  task automatic test_pattern();
    tm = 1'b1;
    for (int c = 0; c < FRAME + 4; c++) begin
      tick();
      n_cmp++;
      if (dut_vec !== e_vec) begin
        n_bad++;
        $display("FAIL bars_vec k=%0d got %h want %h", k, dut_vec, e_vec);
      end
      if (out_v >= 0 && c >= 3) begin
        n_cmp++;
        if (bus.o_de !== 1'b1) begin
          if (bus.o_pixel !== 16'h0) begin
            n_bad++;
            $display("FAIL bars_blank got %h want 0000", bus.o_pixel);
          end
        end else if (out_h < HA / 8) begin
          if (bus.o_pixel !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL bars_left got %h want ffff", bus.o_pixel);
          end
        end else if (out_h >= HA - HA / 8) begin
          if (bus.o_pixel !== 16'h0000) begin
            n_bad++;
            $display("FAIL bars_right got %h want 0000", bus.o_pixel);
          end
        end
      end
    end
    for (int c = 0; c < FRAME; c++) begin
      tick();
      n_cmp++;
      if (dut_vec !== e_vec) begin
        n_bad++;
        $display("FAIL tm_toggle_vec k=%0d got %h want %h", k, dut_vec, e_vec);
      end
      tm = 1'($urandom_range(0, 1));
    end
    tm = 1'b0;
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 3 * FRAME; c++) begin
      tick();
      n_cmp++;
      if (dut_vec !== e_vec) begin
        n_bad++;
        $display("FAIL random_vec k=%0d got %h want %h", k, dut_vec, e_vec);
      end
      i_rstn = ($urandom_range(0, 599) != 0);
`ifdef FB_TEST_PATTERN_EN
      if ($urandom_range(0, 99) == 0) tm = ~tm;
`endif
    end
    i_rstn = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at k=%0d", k);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_frame();
    test_sync();
    test_mid_reset();
`ifdef FB_TEST_PATTERN_EN
    test_pattern();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fb_display_reader.md
FB_DISPLAY_READER -- requirements
Module: fb_display_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 16: pixel width, RGB565.
REQ-002 Parameters H_ACTIVE/H_FP/H_SYNC/H_BP, defaults 640/16/96/48; V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33: display timing.
REQ-003 Parameters FB_WIDTH/FB_HEIGHT, defaults 320/240: frame-buffer geometry; AW = $clog2(FB_WIDTH*FB_HEIGHT).
REQ-004 i_clk  in  1  pixel clock; also drives the frame-buffer read-port clock.
REQ-005 i_rstn  in  1  reset; synchronous, active-low, on i_clk.
REQ-006 o_raddr  out  AW  frame-buffer read address.
REQ-007 i_rdata  in  DATA_WIDTH  frame-buffer read data; valid one cycle after o_raddr.
REQ-008 o_pixel  out  DATA_WIDTH  output pixel, RGB565.
REQ-009 o_hsync, o_vsync  out  1 each  syncs, active-low.
REQ-010 o_de  out  1  active-video qualifier.
REQ-011 o_sof  out  1  one-cycle start-of-frame pulse.

Function
REQ-012 Free-running hcount runs 0..H_TOTAL-1 (H_TOTAL = sum of H_* = 800); at wrap, vcount increments over 0..V_TOTAL-1 (525); vcount wraps to 0 when both counters are at their maxima.
REQ-013 Active region is hcount<H_ACTIVE and vcount<V_ACTIVE; hsync is asserted for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync is defined the same way on vcount.
REQ-014 Upscaling is 2x in both axes; frame-buffer pixel = (vcount>>1)*FB_WIDTH + (hcount>>1).
REQ-015 No multiplier: row_base is cleared at vcount==0 and incremented by FB_WIDTH at the end of each odd active line; o_raddr = row_base + (hcount>>1).
REQ-016 Pipeline: stage 0 counters; stage 1 registered o_raddr; stage 2 BRAM i_rdata; stage 3 registered outputs. o_pixel, o_hsync, o_vsync, o_de and o_sof all update at stage 3, 3 cycles after the counter state that produced them, and are mutually aligned.
REQ-017 During blanking, o_raddr holds its last value and o_pixel = 0.
REQ-018 o_sof = 1 exactly on the stage-3 cycle of hcount=0, vcount=0, coincident with the first o_de of the frame.
REQ-019 Last active pixel (639,479) reads address FB_WIDTH*FB_HEIGHT-1 (76799); o_raddr never exceeds this value.
REQ-020 o_raddr changes at most every second active cycle; each frame-buffer address is presented on 2 consecutive cycles on each of 2 consecutive lines.

Reset
REQ-021 While i_rstn=0 at a clock edge: hcount, vcount, row_base and o_raddr clear to 0; o_pixel=0, o_de=0, o_sof=0, o_hsync=1, o_vsync=1 on the next edge; all pipeline stages are cleared.
REQ-022 Reset mid-frame is legal; after release, timing restarts at (0,0) and the first o_sof occurs exactly 3 cycles after the first non-reset edge.

Configuration
REQ-023 Macro FB_TEST_PATTERN_EN: when defined, adds input i_test_mode (1 bit); with i_test_mode=1, active o_pixel is colour bars keyed on hcount/80 instead of i_rdata: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000. Timing and latency are identical in both modes.
REQ-024 When FB_TEST_PATTERN_EN is undefined, i_test_mode is absent and o_pixel always comes from i_rdata.

Structure
REQ-025 Shared package display_pkg holds the 640x480@60 timing constants, FB geometry constants, and the RGB565 bar colour constants.
REQ-026 Sub-module vga_timing holds the counters and the raw sync/active/sof generation; fb_display_reader holds address generation, the pipeline and output muxing.

Verification
REQ-027 Release reset; count clocks between o_sof pulses -> exactly 420000; o_de high for 307200 cycles per frame; 640 o_de cycles per line.
REQ-028 BRAM model returns data = address -> at line 0, o_pixel sequence is 0,0,1,1,...,319,319; lines 0 and 1 are identical; line 2 starts at 320; pixel (639,479) = 76799.
REQ-029 Sync check -> o_hsync low for 96 cycles, starting 16 cycles after o_de falls; o_vsync low for 2 full lines, starting 10 lines after the last active line.
REQ-030 Assert i_rstn=0 at hcount=300, vcount=200 for 5 cycles -> outputs take reset values the next cycle; o_sof occurs 3 cycles after release; o_raddr restarts at 0.
REQ-031 With FB_TEST_PATTERN_EN and i_test_mode=1 -> o_pixel = FFFF for x 0..79 and 0000 for x 560..639 on every line; o_pixel = 0 in blanking.
